// File: rtl/tone_arbiter.sv
// Two-requester buzzer arbiter: fixed priority A>B, square-wave divider, silent guard gap between tones.
// Optional B-preemption by req_a is enabled with `define TONE_PREEMPT_EN.
module tone_arbiter #(
  parameter int unsigned HALF_A     = 172652,
  parameter int unsigned HALF_B     = 568182,
  parameter int unsigned GAP_CYCLES = 1250000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       req_a,
  input  logic       req_b,
  output logic       spk,
  output logic [1:0] gnt,
  output logic       busy,
  output logic       done
);

  localparam int unsigned HALF_MAX = (HALF_A > HALF_B) ? HALF_A : HALF_B;
  localparam int unsigned HW       = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
  localparam int unsigned GW       = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            spk_q, spk_d;
  logic [1:0]      gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [HW-1:0]   half_cnt_q, half_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [HW-1:0]   half_last;
  logic            play_end;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      spk_q      <= 1'b0;
      gnt_q      <= 2'b00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      half_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      spk_q      <= spk_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      half_cnt_q <= half_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  // Half-period limit and tone-end condition follow the current grant
  always_comb begin
    half_last = gnt_q[1] ? HW'(HALF_B - 1) : HW'(HALF_A - 1);
    play_end  = gnt_q[1] ? ~req_b : ~req_a;
`ifdef TONE_PREEMPT_EN
    play_end  = play_end | (gnt_q[1] & req_a);
`endif
  end

  always_comb begin
    state_d    = state_q;
    spk_d      = spk_q;
    gnt_d      = gnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    half_cnt_d = half_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        spk_d      = 1'b0;
        gnt_d      = 2'b00;
        busy_d     = 1'b0;
        half_cnt_d = '0;
        gap_cnt_d  = '0;
        if (req_a || req_b) begin
          state_d = ST_PLAY;
          gnt_d   = req_a ? 2'b01 : 2'b10;
          spk_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_PLAY: begin
        busy_d = 1'b1;
        if (play_end) begin
          state_d    = ST_GAP;
          spk_d      = 1'b0;
          gnt_d      = 2'b00;
          done_d     = 1'b1;
          gap_cnt_d  = '0;
          half_cnt_d = '0;
        end else if (half_cnt_q == half_last) begin
          spk_d      = ~spk_q;
          half_cnt_d = '0;
        end else begin
          half_cnt_d = half_cnt_q + HW'(1);
        end
      end
      ST_GAP: begin
        spk_d  = 1'b0;
        gnt_d  = 2'b00;
        busy_d = 1'b1;
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        spk_d      = 1'b0;
        gnt_d      = 2'b00;
        busy_d     = 1'b0;
        half_cnt_d = '0;
        gap_cnt_d  = '0;
      end
    endcase
  end

  assign spk  = spk_q;
  assign gnt  = gnt_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_tone_arbiter.sv
// Directed bench for tone_arbiter with small half-periods and gap (HALF_A=4, HALF_B=10, GAP=8).
module tb_tone_arbiter;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       req_a = 1'b0;
  logic       req_b = 1'b0;
  logic       spk;
  logic [1:0] gnt;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;

  tone_arbiter #(.HALF_A(4), .HALF_B(10), .GAP_CYCLES(8)) dut (
    .clk  (clk),
    .clr  (clr),
    .req_a(req_a),
    .req_b(req_b),
    .spk  (spk),
    .gnt  (gnt),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic e_spk, input logic [1:0] e_gnt,
                      input logic e_busy, input logic e_done);
    chk({tag, ".spk"},  32'(spk),  32'(e_spk));
    chk({tag, ".gnt"},  32'(gnt),  32'(e_gnt));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".done"}, 32'(done), 32'(e_done));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. asynchronous reset with req_a held
    req_a = 1'b1;
    #2 clr = 1'b1;
    #1 outs("rst_immediate", 1'b0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      outs("rst_hold", 1'b0, 2'b00, 1'b0, 1'b0);
    end
    clr = 1'b0;
    #1 outs("rst_released", 1'b0, 2'b00, 1'b0, 1'b0);
    step();
    outs("a_grant", 1'b1, 2'b01, 1'b1, 1'b0);

    // 2. tone A square wave, 4 high / 4 low
    for (int i = 0; i < 40; i++) begin
      if (i != 0) step();
      chk("a_wave.spk", 32'(spk), ((i / 4) % 2 == 0) ? 32'd1 : 32'd0);
      chk("a_wave.gnt", 32'(gnt), 32'd1);
    end

    // End A, run the gap to IDLE
    req_a = 1'b0;
    step();
    outs("a_done", 1'b0, 2'b00, 1'b1, 1'b1);
    for (int k = 1; k < 8; k++) begin
      step();
      outs("a_gap", 1'b0, 2'b00, 1'b1, 1'b0);
    end
    step();
    outs("a_idle", 1'b0, 2'b00, 1'b0, 1'b0);

    // 3. tie in IDLE, then handoff to B
    req_a = 1'b1;
    req_b = 1'b1;
    step();
    outs("tie_grant", 1'b1, 2'b01, 1'b1, 1'b0);
    step();
    step();
    chk("tie_hold.gnt", 32'(gnt), 32'd1);
    req_a = 1'b0;
    step();
    outs("tie_done", 1'b0, 2'b00, 1'b1, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("handoff_gap.gnt", 32'(gnt), 32'd0);
      chk("handoff_gap.spk", 32'(spk), 32'd0);
      chk("handoff_gap.busy", 32'(busy), (k == 8) ? 32'd0 : 32'd1);
    end
    step();
    outs("b_grant", 1'b1, 2'b10, 1'b1, 1'b0);
    for (int j = 1; j < 25; j++) begin
      step();
      chk("b_wave.spk", 32'(spk), ((j / 10) % 2 == 0) ? 32'd1 : 32'd0);
      chk("b_wave.gnt", 32'(gnt), 32'd2);
    end

    // 4. req_a while B plays
    req_a = 1'b1;
`ifdef TONE_PREEMPT_EN
    step();
    outs("preempt_done", 1'b0, 2'b00, 1'b1, 1'b1);
    req_b = 1'b0;
`else
    for (int k = 0; k < 5; k++) begin
      step();
      chk("no_preempt.gnt", 32'(gnt), 32'd2);
      chk("no_preempt.done", 32'(done), 32'd0);
    end
    req_b = 1'b0;
    step();
    outs("b_done", 1'b0, 2'b00, 1'b1, 1'b1);
`endif
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("post_b_gap.gnt", 32'(gnt), 32'd0);
    end
    step();
    outs("a_after_gap", 1'b1, 2'b01, 1'b1, 1'b0);

    // 5. async reset pulse mid-PLAY
    step();
    step();
    chk("pre_clr.gnt", 32'(gnt), 32'd1);
    #1 clr = 1'b1;
    #1 outs("clr_mid_play", 1'b0, 2'b00, 1'b0, 1'b0);
    #2 clr = 1'b0;
    req_a = 1'b0;
    step();
    outs("after_clr", 1'b0, 2'b00, 1'b0, 1'b0);
    step();
    outs("after_clr2", 1'b0, 2'b00, 1'b0, 1'b0);

    // 6. one-cycle req_b, then a 3-cycle req_a lost inside the gap
    req_b = 1'b1;
    step();
    outs("short_b_play", 1'b1, 2'b10, 1'b1, 1'b0);
    req_b = 1'b0;
    step();
    outs("short_b_done", 1'b0, 2'b00, 1'b1, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("short_gap.gnt", 32'(gnt), 32'd0);
      chk("short_gap.busy", 32'(busy), (k == 8) ? 32'd0 : 32'd1);
      if (k == 2) req_a = 1'b1;
      if (k == 5) req_a = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      step();
      outs("lost_req", 1'b0, 2'b00, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
